vga_scan_out: RTL



---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_scan_out_if.sv | 25 ++
 rtl/vga_timing_counter.sv | 71 +++++++
 rtl/vga_scan_out.sv | 93 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and pixel type for the 12-bit RGB display path.
// Consumed by vga_scan_out, its timing counter and pixel_operator.
package vga_pkg;
   localparam int RGB_W = 12;

   localparam int VGA_CLK_DIV  = 4;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   typedef logic [RGB_W-1:0] rgb_t;
endpackage

// File: rtl/vga_scan_out_if.sv
// Frame-buffer / operator / pin bundle of vga_scan_out.
// master is the scan-out side, slave is the frame-buffer, operator and pin side.
interface vga_scan_out_if
   import vga_pkg::*;
#(
   parameter int ADDR_W = 15
);
   logic [1:0]        mode_in;
   logic [1:0]        mode_out;
   logic [ADDR_W-1:0] fb_addr;
   rgb_t              pixel_in;
   rgb_t              vga_rgb;
   logic              vga_hsync;
   logic              vga_vsync;
   logic              frame_start;

   modport master (
      input  mode_in, pixel_in,
      output mode_out, fb_addr, vga_rgb, vga_hsync, vga_vsync, frame_start
   );
   modport slave (
      output mode_in, pixel_in,
      input  mode_out, fb_addr, vga_rgb, vga_hsync, vga_vsync, frame_start
   );
endinterface

// File: rtl/vga_timing_counter.sv
// Pixel divider plus h/v raster counters; decodes are for the position the
// counters move to on the current tick, so callers can register them in step.
module vga_timing_counter
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int H_W     = $clog2(H_TOTAL),
   localparam int V_W     = $clog2(V_TOTAL),
   localparam int D_W     = $clog2(CLK_DIV)
) (
   input  logic           clock,
   input  logic           reset_n,
   output logic           tick,
   output logic [H_W-1:0] h_nxt,
   output logic [V_W-1:0] v_nxt,
   output logic           active_nxt,
   output logic           hsync_nxt,
   output logic           vsync_nxt,
   output logic           sof_nxt,
   output logic           frame_start
);
   logic [D_W-1:0] div_cnt;
   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;

   assign tick = (div_cnt == D_W'(CLK_DIV - 1));

   always_comb begin
      h_nxt = h_cnt + 1'b1;
      v_nxt = v_cnt;
      if (int'(h_cnt) == H_TOTAL - 1) begin
         h_nxt = '0;
         v_nxt = (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
      end
   end

   always_comb begin
      active_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      hsync_nxt  = (int'(h_nxt) >= H_ACTIVE + H_FP) &&
                   (int'(h_nxt) <  H_ACTIVE + H_FP + H_SYNC);
      vsync_nxt  = (int'(v_nxt) >= V_ACTIVE + V_FP) &&
                   (int'(v_nxt) <  V_ACTIVE + V_FP + V_SYNC);
      sof_nxt    = (h_nxt == '0) && (v_nxt == '0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt     <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= tick ? '0 : div_cnt + 1'b1;
         frame_start <= tick && sof_nxt;
         if (tick) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
         end
      end
   end
endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: window address fetch, one-pixel output stage aligning rgb with
// the syncs, and a per-frame latch of the operator mode.
module vga_scan_out
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int WIN_X0   = 0,
   parameter int WIN_Y0   = 0,
   parameter int IMG_W    = 160,
   parameter int IMG_H    = 120,
   parameter int ADDR_W   = 15,
   localparam int H_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int V_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          clock,
   input  logic          reset_n,
   vga_scan_out_if.master bus
);
   logic           tick;
   logic [H_W-1:0] h_nxt;
   logic [V_W-1:0] v_nxt;
   logic           active_nxt, hsync_nxt, vsync_nxt, sof_nxt;
   logic           in_win_nxt;
   logic [ADDR_W-1:0] row_base, row_base_nxt, col_nxt;
   logic           win_d, hs_d, vs_d;

   vga_timing_counter #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clock      (clock),
      .reset_n    (reset_n),
      .tick       (tick),
      .h_nxt      (h_nxt),
      .v_nxt      (v_nxt),
      .active_nxt (active_nxt),
      .hsync_nxt  (hsync_nxt),
      .vsync_nxt  (vsync_nxt),
      .sof_nxt    (sof_nxt),
      .frame_start(bus.frame_start)
   );

   // Row base steps by IMG_W at each line start inside the window rows, so
   // the address is row base plus column without any multiply.
   always_comb begin
      in_win_nxt = active_nxt &&
                   (int'(h_nxt) >= WIN_X0) && (int'(h_nxt) < WIN_X0 + IMG_W) &&
                   (int'(v_nxt) >= WIN_Y0) && (int'(v_nxt) < WIN_Y0 + IMG_H);
      row_base_nxt = row_base;
      if (h_nxt == '0) begin
         if (int'(v_nxt) == WIN_Y0)
            row_base_nxt = '0;
         else if (int'(v_nxt) > WIN_Y0)
            row_base_nxt = row_base + ADDR_W'(IMG_W);
      end
      col_nxt = ADDR_W'(int'(h_nxt) - WIN_X0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row_base      <= '0;
         bus.fb_addr   <= '0;
         win_d         <= 1'b0;
         hs_d          <= 1'b0;
         vs_d          <= 1'b0;
         bus.vga_rgb   <= '0;
         bus.vga_hsync <= 1'b1;
         bus.vga_vsync <= 1'b1;
         bus.mode_out  <= 2'b00;
      end else if (tick) begin
         row_base      <= row_base_nxt;
         bus.fb_addr   <= in_win_nxt ? row_base_nxt + col_nxt : '0;
         win_d         <= in_win_nxt;
         hs_d          <= hsync_nxt;
         vs_d          <= vsync_nxt;
         // pixel_in now holds the data for the address issued one tick ago
         bus.vga_rgb   <= win_d ? bus.pixel_in : '0;
         bus.vga_hsync <= ~hs_d;
         bus.vga_vsync <= ~vs_d;
         if (sof_nxt)
            bus.mode_out <= bus.mode_in;
      end
   end
endmodule
